// File: rtl/sva_thread_sched.sv
// Assertion-thread scheduler: holds a compacted pool of live thread slots and
// walks each one, plus an optional new thread, through a shared evaluation engine per epoch.
module sva_thread_sched #(
    parameter int NSLOT   = 4,
    parameter int STATE_W = 4,
    parameter int TIMER_W = 8
) (
    input  logic                       gclk,
    input  logic                       grst,
    input  logic                       sample_valid,
    input  logic                       spawn_en,
    output logic                       busy,
    output logic                       overrun,
    output logic                       eval_req,
    output logic [STATE_W-1:0]         eval_state,
    output logic [TIMER_W-1:0]         eval_start,
    input  logic                       eval_ack,
    input  logic [STATE_W-1:0]         eval_next_state,
    input  logic                       eval_next_active,
    input  logic [1:0]                 eval_verdict,
    output logic                       epoch_done,
    output logic [$clog2(NSLOT+1)-1:0] live_cnt,
    output logic [TIMER_W-1:0]         epoch_cnt,
    output logic [15:0]                succ_cnt,
    output logic [15:0]                fail_cnt,
    output logic [15:0]                lazy_cnt,
    output logic                       overflow
);

    localparam int CNT_W = $clog2(NSLOT + 1);
    localparam int IDX_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [CNT_W-1:0] ONE     = 1;
    localparam logic [CNT_W-1:0] NSLOT_C = CNT_W'(NSLOT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_SPAWN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state_reg, state_next;
    logic [CNT_W-1:0]   rd_reg, rd_next;
    logic [CNT_W-1:0]   wr_reg, wr_next;
    logic [CNT_W-1:0]   live_reg, live_next;
    logic               spawn_reg, spawn_next;
    logic [TIMER_W-1:0] epoch_reg, epoch_next;
    logic               overrun_reg, overrun_next;
    logic               overflow_reg, overflow_next;

    logic [STATE_W-1:0] slot_state [NSLOT];
    logic [TIMER_W-1:0] slot_start [NSLOT];

    logic               xfer;
    logic               slot_we;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic [CNT_W-1:0]   rd_inc;
    logic [STATE_W-1:0] wdata_state;
    logic [TIMER_W-1:0] wdata_start;

    assign rd_idx = rd_reg[IDX_W-1:0];
    assign wr_idx = wr_reg[IDX_W-1:0];
    assign rd_inc = rd_reg + ONE;

    // Request is decoded straight from the state so a reset drops it without waiting for a clock.
    assign eval_req   = (state_reg == S_ISSUE) || (state_reg == S_SPAWN);
    assign busy       = (state_reg != S_IDLE);
    assign epoch_done = (state_reg == S_DONE);
    assign xfer       = eval_req && eval_ack;

    assign eval_state = (state_reg == S_ISSUE) ? slot_state[rd_idx] : '0;
    assign eval_start = (state_reg == S_ISSUE) ? slot_start[rd_idx] :
                        (state_reg == S_SPAWN) ? epoch_reg : '0;

    assign overrun   = overrun_reg;
    assign overflow  = overflow_reg;
    assign live_cnt  = live_reg;
    assign epoch_cnt = epoch_reg;

    always_comb begin
        state_next    = state_reg;
        rd_next       = rd_reg;
        wr_next       = wr_reg;
        live_next     = live_reg;
        spawn_next    = spawn_reg;
        epoch_next    = epoch_reg;
        overflow_next = 1'b0;
        overrun_next  = sample_valid && (state_reg != S_IDLE);
        slot_we       = 1'b0;
        wdata_state   = eval_next_state;
        wdata_start   = (state_reg == S_ISSUE) ? slot_start[rd_idx] : epoch_reg;

        case (state_reg)
            S_IDLE: begin
                if (sample_valid) begin
                    spawn_next = spawn_en;
                    rd_next    = '0;
                    wr_next    = '0;
                    if (live_reg != '0)
                        state_next = S_ISSUE;
                    else if (spawn_en)
                        state_next = S_SPAWN;
                    else
                        state_next = S_DONE;
                end
            end
            S_ISSUE: begin
                if (eval_ack) begin
                    // wr never passes rd, so survivors compact downward without clobbering unread slots.
                    if (eval_next_active) begin
                        slot_we = 1'b1;
                        wr_next = wr_reg + ONE;
                    end
                    rd_next = rd_inc;
                    if (rd_inc == live_reg)
                        state_next = spawn_reg ? S_SPAWN : S_DONE;
                end
            end
            S_SPAWN: begin
                if (eval_ack) begin
                    if (eval_next_active) begin
                        if (wr_reg < NSLOT_C) begin
                            slot_we = 1'b1;
                            wr_next = wr_reg + ONE;
                        end else begin
                            overflow_next = 1'b1;
                        end
                    end
                    state_next = S_DONE;
                end
            end
            default: begin
                live_next  = wr_reg;
                epoch_next = epoch_reg + 1'b1;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            state_reg    <= S_IDLE;
            rd_reg       <= '0;
            wr_reg       <= '0;
            live_reg     <= '0;
            spawn_reg    <= 1'b0;
            epoch_reg    <= '0;
            overrun_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_reg       <= rd_next;
            wr_reg       <= wr_next;
            live_reg     <= live_next;
            spawn_reg    <= spawn_next;
            epoch_reg    <= epoch_next;
            overrun_reg  <= overrun_next;
            overflow_reg <= overflow_next;
        end
    end

    // Slot payload needs no reset: only slots below live_cnt are ever read.
    always_ff @(posedge gclk) begin
        if (slot_we) begin
            slot_state[wr_idx] <= wdata_state;
            slot_start[wr_idx] <= wdata_start;
        end
    end

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_cnt
        logic [15:0] cnt_reg;
        always_ff @(posedge gclk or posedge grst) begin
            if (grst)
                cnt_reg <= '0;
            else if (xfer && (eval_verdict == 2'(gi + 1)) && (cnt_reg != 16'hFFFF))
                cnt_reg <= cnt_reg + 16'd1;
        end
    end

    assign succ_cnt = g_cnt[0].cnt_reg;
    assign fail_cnt = g_cnt[1].cnt_reg;
    assign lazy_cnt = g_cnt[2].cnt_reg;

endmodule
